// File: rtl/mil1553_spi_pkg.sv
// Shared definitions for the MIL-1553 / SPI status path: reader FSM states
// and the default capture depth and timeout constants.
package mil1553_spi_pkg;

  localparam int DEFAULT_MAX_WORDS      = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FINISH,
    FAIL
  } reader_state_t;

endpackage

// File: rtl/IPop.sv
// Pop handshake toward a word source: the master pulses request, and the
// source answers later with done plus data for one cycle.
interface IPop;
  logic        request;
  logic [15:0] data;
  logic        done;

  modport master (output request, input data, input done);
  modport slave  (input request, output data, output done);
endinterface

// File: rtl/reader_timeout.sv
// Loadable saturating down-counter; o_expired flags that the WAIT budget
// for the outstanding request is used up.
module reader_timeout
  import mil1553_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Loading TIMEOUT_CYCLES-1 lets exactly TIMEOUT_CYCLES silent WAIT cycles
  // pass; the last one sees o_expired and the reader moves to FAIL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(TIMEOUT_CYCLES - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/status_reader.sv
// Burst reader: pops up to MAX_WORDS 16-bit words from an IPop source into a
// small capture buffer, with a per-word timeout and combinational readback.
module status_reader
  import mil1553_spi_pkg::*;
#(
  parameter  int MAX_WORDS      = DEFAULT_MAX_WORDS,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int AW             = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int CW             = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  IPop.master           in,
  input  logic          start,
  input  logic [CW-1:0] wordCount,
  output logic          busy,
  output logic          complete,
  output logic          timeoutErr,
  output logic [CW-1:0] wordsRead,
  input  logic [AW-1:0] readAddr,
  output logic [15:0]   readData
);

  reader_state_t r_state;
  reader_state_t w_state_next;
  logic [CW-1:0] r_words_read;
  logic [CW-1:0] r_target;
  logic [CW-1:0] w_target_clamped;
  logic [15:0]   r_buf [MAX_WORDS];
  logic          w_capture;
  logic          w_load;
  logic          w_dec;
  logic          w_expired;
  logic          w_request;

  assign w_target_clamped = (wordCount > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : wordCount;
  assign w_capture        = (r_state == WAIT) && in.done;
  assign w_load           = (r_state == REQ);
  assign w_dec            = (r_state == WAIT) && !in.done;

  reader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_dec    (w_dec),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_words_read <= '0;
      r_target     <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && start) begin
        r_target     <= w_target_clamped;
        r_words_read <= '0;
      end else if (w_capture) begin
        r_words_read <= r_words_read + CW'(1);
      end
    end
  end

  // Buffer has no reset; a word presented while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      r_buf[r_words_read[AW-1:0]] <= in.data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_request    = 1'b0;
    busy         = 1'b1;
    complete     = 1'b0;
    timeoutErr   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (wordCount == '0) ? FINISH : REQ;
        end
      end
      REQ: begin
        w_request    = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // A word arriving on the last budgeted cycle still wins over timeout.
        if (in.done) begin
          w_state_next = ((r_words_read + CW'(1)) == r_target) ? FINISH : REQ;
        end else if (w_expired) begin
          w_state_next = FAIL;
        end
      end
      FINISH: begin
        complete     = 1'b1;
        w_state_next = IDLE;
      end
      FAIL: begin
        timeoutErr   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign in.request = w_request;
  assign wordsRead  = r_words_read;
  assign readData   = r_buf[readAddr];

endmodule
